ushift_seq_ctrl: RTL and testbench

Command sequencer for the universal shift register (4-bit default; mode 00 hold, 01 shift left, 10 shift right, 11 parallel load).
- Accepts one command at a time on a valid/ready interface.
- Drives the register's en/mode/data_in/serial-fill inputs for the right number of cycles.
- Streams out the bits shifted out of the register.
- Pulses done when the command completes.
- Sits between a bus-side master and one shift-register instance.

---
 rtl/ushift_seq_ctrl_if.sv | 25 ++
 rtl/ushift_seq_ctrl.sv | 160 ++++++++++++++++
 tb/tb_ushift_seq_ctrl.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/ushift_seq_ctrl_if.sv
// Command handshake bundle for ushift_seq_ctrl.
// Master drives a command; slave raises cmd_ready when idle.
interface ushift_seq_ctrl_if #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 3
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [2:0]       cmd_op;
  logic [CNT_W-1:0] cmd_count;
  logic [WIDTH-1:0] cmd_data;
  logic             cmd_fill;

  modport master (
    output cmd_valid, cmd_op, cmd_count,
    output cmd_data, cmd_fill,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_count,
    input  cmd_data, cmd_fill,
    output cmd_ready
  );
endinterface

// File: rtl/ushift_seq_ctrl.sv
// Command sequencer for a universal shift register.
// USHIFT_SEQ_ROTATE_EN enables ROL/ROR; otherwise they end with err.
module ushift_seq_ctrl #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             reset,
  ushift_seq_ctrl_if.slave cmd,
  output logic             sr_en,
  output logic [1:0]       sr_mode,
  output logic [WIDTH-1:0] sr_data_in,
  output logic             sr_sft_left,
  output logic             sr_sft_right,
  input  logic             sr_q_left,
  input  logic             sr_q_right,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             busy,
  output logic             done,
  output logic             err
);

  typedef enum logic [1:0] {
    S_IDLE, S_LOAD, S_SHIFT, S_DONE
  } state_t;

  localparam logic [2:0] OP_LOAD = 3'd1;
  localparam logic [2:0] OP_SHL  = 3'd2;
  localparam logic [2:0] OP_SHR  = 3'd3;
  localparam logic [2:0] OP_ROL  = 3'd4;
  localparam logic [2:0] OP_ROR  = 3'd5;
  localparam logic [2:0] OP_LSHL = 3'd6;
  localparam logic [2:0] OP_LSHR = 3'd7;

  state_t           state_q, state_d;
  logic [2:0]       op_q, op_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             fill_q, fill_d;
  logic             err_q, err_d;

  logic c_load, c_shift, c_rot, c_zero;
  logic left_q, lsh_q;

  assign c_load  = (cmd.cmd_op == OP_LOAD) ||
                   (cmd.cmd_op == OP_LSHL) ||
                   (cmd.cmd_op == OP_LSHR);
  assign c_shift = (cmd.cmd_op == OP_SHL) ||
                   (cmd.cmd_op == OP_SHR);
  assign c_rot   = (cmd.cmd_op == OP_ROL) ||
                   (cmd.cmd_op == OP_ROR);
  assign c_zero  = (cmd.cmd_count == '0);

  assign left_q = (op_q == OP_SHL) ||
                  (op_q == OP_ROL) ||
                  (op_q == OP_LSHL);
  assign lsh_q  = (op_q == OP_LSHL) ||
                  (op_q == OP_LSHR);

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    fill_d  = fill_q;
    err_d   = err_q;
    unique case (state_q)
      S_IDLE: begin
        if (cmd.cmd_valid) begin
          op_d   = cmd.cmd_op;
          cnt_d  = cmd.cmd_count;
          data_d = cmd.cmd_data;
          fill_d = cmd.cmd_fill;
          err_d  = 1'b0;
          unique case (1'b1)
            c_load:  state_d = S_LOAD;
            c_shift: state_d = c_zero ? S_DONE : S_SHIFT;
`ifdef USHIFT_SEQ_ROTATE_EN
            c_rot:   state_d = c_zero ? S_DONE : S_SHIFT;
`else
            c_rot: begin
              err_d   = 1'b1;
              state_d = S_DONE;
            end
`endif
            default: state_d = S_DONE;
          endcase
        end
      end
      S_LOAD: begin
        if (lsh_q && cnt_q != '0)
          state_d = S_SHIFT;
        else
          state_d = S_DONE;
      end
      S_SHIFT: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1))
          state_d = S_DONE;
      end
      S_DONE: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      fill_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      fill_q  <= fill_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    cmd.cmd_ready = (state_q == S_IDLE);
    busy          = (state_q != S_IDLE);
    done          = (state_q == S_DONE);
    err           = err_q && (state_q == S_DONE);
    sr_en         = 1'b0;
    sr_mode       = 2'b00;
    sr_data_in    = '0;
    sr_sft_left   = 1'b0;
    sr_sft_right  = 1'b0;
    ser_out       = 1'b0;
    ser_valid     = 1'b0;
    if (state_q == S_LOAD) begin
      sr_en      = 1'b1;
      sr_mode    = 2'b11;
      sr_data_in = data_q;
    end
    if (state_q == S_SHIFT) begin
      sr_en     = 1'b1;
      sr_mode   = left_q ? 2'b01 : 2'b10;
      ser_valid = 1'b1;
      ser_out   = left_q ? sr_q_left : sr_q_right;
      if (left_q)
        sr_sft_left = fill_q;
      else
        sr_sft_right = fill_q;
`ifdef USHIFT_SEQ_ROTATE_EN
      // Rotate recirculates the outgoing bit in the same cycle.
      if (op_q == OP_ROL)
        sr_sft_left = sr_q_left;
      if (op_q == OP_ROR)
        sr_sft_right = sr_q_right;
`endif
    end
  end

endmodule

// File: tb/tb_ushift_seq_ctrl.sv
// Bench for ushift_seq_ctrl: a behavioural shift register plant
// plus an arithmetic reference model per command.
module tb_ushift_seq_ctrl;
  localparam int W  = 4;
  localparam int CW = 3;
`ifdef USHIFT_SEQ_ROTATE_EN
  localparam bit ROT_EN = 1'b1;
`else
  localparam bit ROT_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  logic sr_en, sr_sft_left, sr_sft_right;
  logic [1:0] sr_mode;
  logic [W-1:0] sr_data_in;
  logic ser_out, ser_valid, busy, done, err;
  logic [W-1:0] sreg;

  int checks = 0;
  int errors = 0;

  ushift_seq_ctrl_if #(.WIDTH(W), .CNT_W(CW)) cif ();

  ushift_seq_ctrl #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk          (clk),
    .reset        (reset),
    .cmd          (cif),
    .sr_en        (sr_en),
    .sr_mode      (sr_mode),
    .sr_data_in   (sr_data_in),
    .sr_sft_left  (sr_sft_left),
    .sr_sft_right (sr_sft_right),
    .sr_q_left    (sreg[W-1]),
    .sr_q_right   (sreg[0]),
    .ser_out      (ser_out),
    .ser_valid    (ser_valid),
    .busy         (busy),
    .done         (done),
    .err          (err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (sr_en) begin
      case (sr_mode)
        2'b01: sreg <= {sreg[W-2:0], sr_sft_left};
        2'b10: sreg <= {sr_sft_right, sreg[W-1:1]};
        2'b11: sreg <= sr_data_in;
        default: ;
      endcase
    end
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_ready();
    int t = 0;
    while (cif.cmd_ready !== 1'b1 && t < 30) begin
      @(negedge clk);
      t++;
    end
    chk("ready_wait", cif.cmd_ready, 1);
  endtask

  task automatic drive(input int op, input int cnt,
                       input int data, input int fill);
    cif.cmd_valid = 1'b1;
    cif.cmd_op    = 3'(op);
    cif.cmd_count = CW'(cnt);
    cif.cmd_data  = W'(data);
    cif.cmd_fill  = fill[0];
  endtask

  // Starts and ends on a negedge with the DUT idle.
  task automatic run_cmd(input int op, input int cnt,
                         input int data, input int fill);
    int unsigned v, inb, outb;
    int unsigned mask = (1 << W) - 1;
    int n, lat, idx;
    bit legal, load, left, rot;
    int bits[$];
    legal = ROT_EN || !(op == 4 || op == 5);
    load  = (op == 1) || (op == 6) || (op == 7);
    rot   = (op == 4) || (op == 5);
    left  = (op == 2) || (op == 4) || (op == 6);
    n     = (legal && op >= 2) ? cnt : 0;
    v     = load ? (data & mask) : int'(sreg);
    for (int i = 0; i < n; i++) begin
      outb = left ? ((v >> (W - 1)) & 1) : (v & 1);
      inb  = rot ? outb : (fill & 1);
      if (left)
        v = ((v << 1) | inb) & mask;
      else
        v = (v >> 1) | (inb << (W - 1));
      bits.push_back(int'(outb));
    end
    lat = (load ? 1 : 0) + n + 1;
    wait_ready();
    drive(op, cnt, data, fill);
    @(posedge clk);
    #1 cif.cmd_valid = 1'b0;
    for (int k = 1; k <= lat; k++) begin
      @(negedge clk);
      if (k == lat) begin
        chk("done", done, 1);
        chk("done_err", err, legal ? 0 : 1);
        chk("done_en", sr_en, 0);
        chk("done_busy", busy, 1);
        chk("done_rdy", cif.cmd_ready, 0);
      end else if (load && k == 1) begin
        chk("ld_en", sr_en, 1);
        chk("ld_mode", sr_mode, 3);
        chk("ld_data", sr_data_in, data & mask);
        chk("ld_done", done, 0);
      end else begin
        idx = k - 1 - (load ? 1 : 0);
        chk("sh_en", sr_en, 1);
        chk("sh_mode", sr_mode, left ? 1 : 2);
        chk("sh_sv", ser_valid, 1);
        chk("sh_out", ser_out, bits[idx]);
        chk("sh_data", sr_data_in, 0);
        chk("sh_done", done, 0);
      end
    end
    @(negedge clk);
    chk("post_done", done, 0);
    chk("post_rdy", cif.cmd_ready, 1);
    chk("reg", sreg, v);
  endtask

  initial begin
    int t;
    reset = 1'b1;
    cif.cmd_valid = 1'b0;
    cif.cmd_op    = '0;
    cif.cmd_count = '0;
    cif.cmd_data  = '0;
    cif.cmd_fill  = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk("rst_rdy", cif.cmd_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_en", sr_en, 0);
    chk("rst_sv", ser_valid, 0);
    chk("rst_so", ser_out, 0);
    chk("rst_mode", sr_mode, 0);
    chk("rst_din", sr_data_in, 0);
    chk("rst_sl", sr_sft_left, 0);
    chk("rst_sr", sr_sft_right, 0);

    run_cmd(1, 0, 4'b1010, 0);
    chk("load_reg", sreg, 4'b1010);
    run_cmd(6, 2, 4'b1010, 1);
    chk("lshl_reg", sreg, 4'b1011);
    run_cmd(1, 0, 4'b1100, 0);
    run_cmd(3, 3, 0, 0);
    chk("shr_reg", sreg, 4'b0001);
    run_cmd(1, 0, 4'b1010, 0);
    run_cmd(4, 4, 0, 0);
    chk("rol_reg", sreg, 4'b1010);
    run_cmd(5, 3, 0, 1);
    run_cmd(2, 0, 0, 1);
    run_cmd(0, 5, 0, 1);
    run_cmd(7, 0, 4'b0110, 1);
    run_cmd(7, 7, 4'b0110, 1);

    // Reset in the middle of a long shift.
    wait_ready();
    drive(2, 5, 0, 0);
    @(posedge clk);
    #1 cif.cmd_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("mid_busy", busy, 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("mr_busy", busy, 0);
    chk("mr_rdy", cif.cmd_ready, 1);
    chk("mr_en", sr_en, 0);
    for (int i = 0; i < 6; i++) begin
      chk("mr_nodone", done, 0);
      @(negedge clk);
    end

    // cmd_valid held through a command is only taken after DONE.
    run_cmd(1, 0, 4'b0000, 0);
    drive(2, 2, 0, 1);
    @(posedge clk);
    @(negedge clk);
    chk("hold_rdy1", cif.cmd_ready, 0);
    @(negedge clk);
    chk("hold_rdy2", cif.cmd_ready, 0);
    @(negedge clk);
    chk("hold_done", done, 1);
    chk("hold_rdy3", cif.cmd_ready, 0);
    @(negedge clk);
    chk("hold_idle", cif.cmd_ready, 1);
    @(negedge clk);
    cif.cmd_valid = 1'b0;
    chk("hold_2nd", busy, 1);
    chk("hold_2en", sr_en, 1);
    t = 0;
    while (done !== 1'b1 && t < 20) begin
      @(negedge clk);
      t++;
    end
    chk("hold_fin", done, 1);
    @(negedge clk);
    chk("hold_reg", sreg, 4'b1111);

    for (int i = 0; i < 40; i++)
      run_cmd(int'($urandom_range(0, 7)),
              int'($urandom_range(0, 7)),
              int'($urandom_range(0, 15)),
              int'($urandom_range(0, 1)));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
